core2avl_mm: RTL and testbench

- Parametrised successor to the core-side load/store-to-Avalon-MM bridge, between the RISC-V core's memory stage and the Avalon-MM interconnect.
- Accepts one load/store at a time. It drives registered Avalon master signals and honours waitrequest.
- Supports pipelined reads through readdatavalid.
- Optionally splits misaligned accesses that cross a word boundary into two bus beats and merges the read data.
- Stalls the core until the access completes.

---
 rtl/core2avl_pkg.sv | 28 ++
 rtl/core2avl_lane_align.sv | 35 +++
 rtl/core2avl_mm.sv | 169 ++++++++++++++++
 tb/tb_core2avl_mm.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core2avl_pkg.sv
// core2avl_pkg: shared encodings, state codes and helpers for the core-to-Avalon bridge
package core2avl_pkg;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;
  localparam logic [2:0] SB  = LB;
  localparam logic [2:0] SH  = LH;
  localparam logic [2:0] SW  = LW;
  localparam logic [2:0] SD  = LD;
  localparam logic [1:0] RW_IDLE  = 2'b00;
  localparam logic [1:0] RW_STORE = 2'b01;
  localparam logic [1:0] RW_LOAD  = 2'b10;
  localparam logic [1:0] RW_ILL   = 2'b11;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_REQ0  = 3'd1;
  localparam state_t S_RESP0 = 3'd2;
  localparam state_t S_REQ1  = 3'd3;
  localparam state_t S_RESP1 = 3'd4;
  localparam state_t S_DONE  = 3'd5;
  function automatic logic [3:0] size_of(input logic [2:0] mode);
    return 4'd1 << mode[1:0];
  endfunction
endpackage

// File: rtl/core2avl_lane_align.sv
// core2avl_lane_align: byte-lane steering for store beats and load merge/extension
module core2avl_lane_align
  import core2avl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
)(
  input  logic [2:0]                       mode_i,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]  off_i,
  input  logic                             beat_i,
  input  logic [DATA_WIDTH-1:0]            wdata_i,
  input  logic [DATA_WIDTH-1:0]            lo_i,
  input  logic [DATA_WIDTH-1:0]            hi_i,
  output logic [DATA_WIDTH/8-1:0]          be_o,
  output logic [DATA_WIDTH-1:0]            wdata_o,
  output logic [DATA_WIDTH-1:0]            rdata_o
);
  localparam int DW = DATA_WIDTH;
  localparam int BW = DW / 8;
  logic [3:0]      sz;
  logic [2*BW-1:0] lanes;
  logic [2*DW-1:0] wide_w;
  logic [DW-1:0]   x;
  logic [DW-1:0]   keep;
  logic            sb;
  assign sz      = size_of(mode_i);
  assign lanes   = ~({(2*BW){1'b1}} << sz) << off_i;
  assign be_o    = beat_i ? lanes[2*BW-1:BW] : lanes[BW-1:0];
  assign wide_w  = {{DW{1'b0}}, wdata_i} << {off_i, 3'b000};
  assign wdata_o = beat_i ? wide_w[2*DW-1:DW] : wide_w[DW-1:0];
  assign x       = DW'({hi_i, lo_i} >> {off_i, 3'b000});
  assign keep    = ~({DW{1'b1}} << {sz, 3'b000});
  // mode[2] marks the unsigned variants; doubleword keeps every bit so its sign is moot
  assign sb      = ~mode_i[2] & (mode_i[1:0] == 2'd0 ? x[7] : mode_i[1:0] == 2'd1 ? x[15] : x[31]);
  assign rdata_o = sb ? (x | ~keep) : (x & keep);
endmodule

// File: rtl/core2avl_mm.sv
// core2avl_mm: single-outstanding load/store bridge from the core memory stage to Avalon-MM
module core2avl_mm
  import core2avl_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
)(
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic [2:0]              mode_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   data2write_i,
  input  logic [1:0]              rw_i,
  output logic [DATA_WIDTH-1:0]   data2read_o,
  output logic                    stall_o,
  output logic                    err_o,
  input  logic [DATA_WIDTH-1:0]   readdata_i,
  input  logic                    readdatavalid_i,
  input  logic                    waitrequest_i,
  output logic [ADDR_WIDTH-1:0]   address_o,
  output logic [DATA_WIDTH-1:0]   writedata_o,
  output logic [DATA_WIDTH/8-1:0] byteenable_o,
  output logic                    read_o,
  output logic                    write_o
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int OW       = $clog2(BE_WIDTH);
  state_t                  state_q, state_d;
  logic [2:0]              mode_q, mode_d;
  logic [OW-1:0]           off_q, off_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   lo_q, lo_d;
  logic [DATA_WIDTH-1:0]   hi_q, hi_d;
  logic [DATA_WIDTH-1:0]   writedata_q, writedata_d;
  logic [ADDR_WIDTH-1:0]   address_q, address_d;
  logic [BE_WIDTH-1:0]     be_q, be_d;
  logic                    store_q, store_d;
  logic                    cross_q, cross_d;
  logic                    read_q, read_d;
  logic                    write_q, write_d;
  logic                    err_q, err_d;
  logic                    idle, req, cross_in, bad, accept;
  logic [OW-1:0]           off_in;
  logic [4:0]              end_in;
  logic [BE_WIDTH-1:0]     al_be;
  logic [DATA_WIDTH-1:0]   al_wd, al_rd;
  assign idle     = state_q == S_IDLE;
  assign req      = rw_i == RW_LOAD || rw_i == RW_STORE;
  assign off_in   = addr_i[OW-1:0];
  assign end_in   = 5'(off_in) + 5'(size_of(mode_i));
  assign cross_in = end_in > 5'(BE_WIDTH);
  assign bad      = mode_i == 3'b111 || (DATA_WIDTH == 32 && (mode_i == LD || mode_i == LWU)) ||
                    (cross_in && !ALLOW_MISALIGNED);
  assign accept   = idle && req && !bad;
  assign stall_o      = reset_ni && (accept || !(idle || state_q == S_DONE));
  assign data2read_o  = (state_q == S_DONE && !store_q) ? al_rd : '0;
  assign err_o        = err_q;
  assign address_o    = address_q;
  assign writedata_o  = writedata_q;
  assign byteenable_o = be_q;
  assign read_o       = read_q;
  assign write_o      = write_q;
  // In IDLE the aligner steers the incoming request for beat 0; afterwards it works on the latched copy
  core2avl_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .mode_i  (idle ? mode_i : mode_q),
    .off_i   (idle ? off_in : off_q),
    .beat_i  (!idle),
    .wdata_i (idle ? data2write_i : wdata_q),
    .lo_i    (lo_q),
    .hi_i    (hi_q),
    .be_o    (al_be),
    .wdata_o (al_wd),
    .rdata_o (al_rd)
  );
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    writedata_d = writedata_q;
    address_d   = address_q;
    be_d        = be_q;
    store_d     = store_q;
    cross_d     = cross_q;
    read_d      = read_q;
    write_d     = write_q;
    err_d       = idle && (rw_i == RW_ILL || (req && bad));
    case (state_q)
      S_IDLE: if (accept) begin
        state_d     = S_REQ0;
        mode_d      = mode_i;
        off_d       = off_in;
        wdata_d     = data2write_i;
        store_d     = rw_i == RW_STORE;
        cross_d     = cross_in;
        read_d      = rw_i == RW_LOAD;
        write_d     = rw_i == RW_STORE;
        address_d   = {addr_i[ADDR_WIDTH-1:OW], {OW{1'b0}}};
        be_d        = al_be;
        writedata_d = al_wd;
      end
      S_REQ0: if (!waitrequest_i) begin
        read_d  = 1'b0;
        write_d = store_q && cross_q;
        state_d = !store_q ? S_RESP0 : cross_q ? S_REQ1 : S_DONE;
        if (store_q && cross_q) begin
          address_d   = address_q + ADDR_WIDTH'(BE_WIDTH);
          be_d        = al_be;
          writedata_d = al_wd;
        end
      end
      S_RESP0: if (readdatavalid_i) begin
        lo_d    = readdata_i;
        read_d  = cross_q;
        state_d = cross_q ? S_REQ1 : S_DONE;
        if (cross_q) begin
          address_d = address_q + ADDR_WIDTH'(BE_WIDTH);
          be_d      = al_be;
        end
      end
      S_REQ1: if (!waitrequest_i) begin
        read_d  = 1'b0;
        write_d = 1'b0;
        state_d = store_q ? S_DONE : S_RESP1;
      end
      S_RESP1: if (readdatavalid_i) begin
        hi_d    = readdata_i;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      off_q       <= '0;
      wdata_q     <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      writedata_q <= '0;
      address_q   <= '0;
      be_q        <= '0;
      store_q     <= 1'b0;
      cross_q     <= 1'b0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      writedata_q <= writedata_d;
      address_q   <= address_d;
      be_q        <= be_d;
      store_q     <= store_d;
      cross_q     <= cross_d;
      read_q      <= read_d;
      write_q     <= write_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_core2avl_mm.sv
// tb_core2avl_mm: directed self-checking bench for the core-to-Avalon bridge
module tb_core2avl_mm;
  import core2avl_pkg::*;
  logic clk = 1'b0;
  logic reset_n;
  logic [2:0] mode;
  logic [31:0] addr, data2write, readdata;
  logic [1:0] rw, rw0;
  logic rdv, waitreq;
  logic [31:0] d2r, address, writedata, d2r0, address0, writedata0;
  logic stall, err, read, write, stall0, err0, read0, write0;
  logic [3:0] be, be0;
  int total = 0;
  int bad = 0;
  logic [31:0] b_addr [2];
  logic [31:0] b_wd [2];
  logic [3:0] b_be [2];
  int nb, cyc;
  logic [31:0] got;

  always #5 clk = ~clk;

  core2avl_mm u_dut (
    .clk_i(clk), .reset_ni(reset_n), .mode_i(mode), .addr_i(addr), .data2write_i(data2write),
    .rw_i(rw), .data2read_o(d2r), .stall_o(stall), .err_o(err), .readdata_i(readdata),
    .readdatavalid_i(rdv), .waitrequest_i(waitreq), .address_o(address), .writedata_o(writedata),
    .byteenable_o(be), .read_o(read), .write_o(write));

  core2avl_mm #(.ALLOW_MISALIGNED(1'b0)) u_dut0 (
    .clk_i(clk), .reset_ni(reset_n), .mode_i(mode), .addr_i(addr), .data2write_i(data2write),
    .rw_i(rw0), .data2read_o(d2r0), .stall_o(stall0), .err_o(err0), .readdata_i(readdata),
    .readdatavalid_i(rdv), .waitrequest_i(waitreq), .address_o(address0), .writedata_o(writedata0),
    .byteenable_o(be0), .read_o(read0), .write_o(write0));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait slave: answers each read strobe with readdatavalid on the following cycle
  task automatic run_access(input logic [2:0] m, input logic [31:0] a, input logic [31:0] wd,
                            input logic [1:0] r, input logic [31:0] rd0, input logic [31:0] rd1);
    logic pend;
    pend = 1'b0;
    nb = 0;
    cyc = -1;
    got = 'x;
    mode = m;
    addr = a;
    data2write = wd;
    rw = r;
    step();
    rw = RW_IDLE;
    #1;
    for (int i = 1; i < 20; i++) begin
      if ((read || write) && nb < 2) begin
        b_addr[nb] = address;
        b_be[nb] = be;
        b_wd[nb] = writedata;
        nb++;
        pend = read;
      end
      if (!stall) begin
        cyc = i;
        got = d2r;
        break;
      end
      step();
      rdv = pend;
      readdata = (nb <= 1) ? rd0 : rd1;
      pend = 1'b0;
      #1;
    end
    step();
    rdv = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    mode = LW;
    addr = 32'h100;
    data2write = 32'h0;
    readdata = 32'h0;
    rw = RW_LOAD;
    rw0 = RW_IDLE;
    rdv = 1'b1;
    waitreq = 1'b0;
    #12;
    total++; if (read !== 1'b0) begin bad++; $display("FAIL reset_read got=%b exp=0", read); end
    total++; if (write !== 1'b0) begin bad++; $display("FAIL reset_write got=%b exp=0", write); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    total++; if (be !== 4'h0) begin bad++; $display("FAIL reset_be got=%h exp=0", be); end
    total++; if (address !== 32'h0) begin bad++; $display("FAIL reset_address got=%h exp=0", address); end
    total++; if (writedata !== 32'h0) begin bad++; $display("FAIL reset_writedata got=%h exp=0", writedata); end
    total++; if (d2r !== 32'h0) begin bad++; $display("FAIL reset_data2read got=%h exp=0", d2r); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
    rw = RW_IDLE;
    rdv = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    total++; if (stall !== 1'b0 || read !== 1'b0) begin bad++; $display("FAIL post_reset_idle got stall=%b read=%b exp 0 0", stall, read); end
  endtask

  task automatic test_aligned_lw();
    run_access(LW, 32'h100, 32'h0, RW_LOAD, 32'hDEADBEEF, 32'h0);
    total++; if (cyc !== 3) begin bad++; $display("FAIL lw_latency got=%0d exp=3", cyc); end
    total++; if (nb !== 1) begin bad++; $display("FAIL lw_beats got=%0d exp=1", nb); end
    total++; if (b_addr[0] !== 32'h100) begin bad++; $display("FAIL lw_address got=%h exp=00000100", b_addr[0]); end
    total++; if (b_be[0] !== 4'b1111) begin bad++; $display("FAIL lw_be got=%b exp=1111", b_be[0]); end
    total++; if (got !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data got=%h exp=deadbeef", got); end
  endtask

  task automatic test_byte_loads();
    run_access(LB, 32'h103, 32'h0, RW_LOAD, 32'h80112233, 32'h0);
    total++; if (b_be[0] !== 4'b1000) begin bad++; $display("FAIL lb_be got=%b exp=1000", b_be[0]); end
    total++; if (got !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_data got=%h exp=ffffff80", got); end
    run_access(LBU, 32'h103, 32'h0, RW_LOAD, 32'h80112233, 32'h0);
    total++; if (got !== 32'h00000080) begin bad++; $display("FAIL lbu_data got=%h exp=00000080", got); end
    run_access(LH, 32'h102, 32'h0, RW_LOAD, 32'h80112233, 32'h0);
    total++; if (b_be[0] !== 4'b1100) begin bad++; $display("FAIL lh_be got=%b exp=1100", b_be[0]); end
    total++; if (got !== 32'hFFFF8011) begin bad++; $display("FAIL lh_data got=%h exp=ffff8011", got); end
    run_access(LHU, 32'h100, 32'h0, RW_LOAD, 32'h80119233, 32'h0);
    total++; if (got !== 32'h00009233) begin bad++; $display("FAIL lhu_data got=%h exp=00009233", got); end
  endtask

  task automatic test_store_half();
    run_access(SH, 32'h102, 32'h00001234, RW_STORE, 32'h0, 32'h0);
    total++; if (cyc !== 2) begin bad++; $display("FAIL sh_latency got=%0d exp=2", cyc); end
    total++; if (b_wd[0] !== 32'h12340000) begin bad++; $display("FAIL sh_writedata got=%h exp=12340000", b_wd[0]); end
    total++; if (b_be[0] !== 4'b1100) begin bad++; $display("FAIL sh_be got=%b exp=1100", b_be[0]); end
    total++; if (got !== 32'h0) begin bad++; $display("FAIL sh_data2read got=%h exp=0", got); end
  endtask

  task automatic test_misaligned();
    run_access(LW, 32'h102, 32'h0, RW_LOAD, 32'hAAAA5566, 32'h7788BBBB);
    total++; if (cyc !== 5) begin bad++; $display("FAIL mlw_latency got=%0d exp=5", cyc); end
    total++; if (nb !== 2) begin bad++; $display("FAIL mlw_beats got=%0d exp=2", nb); end
    total++; if (b_addr[0] !== 32'h100 || b_be[0] !== 4'b1100) begin bad++; $display("FAIL mlw_beat0 got=%h/%b exp=00000100/1100", b_addr[0], b_be[0]); end
    total++; if (b_addr[1] !== 32'h104 || b_be[1] !== 4'b0011) begin bad++; $display("FAIL mlw_beat1 got=%h/%b exp=00000104/0011", b_addr[1], b_be[1]); end
    total++; if (got !== 32'hBBBBAAAA) begin bad++; $display("FAIL mlw_data got=%h exp=bbbbaaaa", got); end
    run_access(SW, 32'h103, 32'h11223344, RW_STORE, 32'h0, 32'h0);
    total++; if (cyc !== 3) begin bad++; $display("FAIL msw_latency got=%0d exp=3", cyc); end
    total++; if (b_wd[0] !== 32'h44000000 || b_be[0] !== 4'b1000) begin bad++; $display("FAIL msw_beat0 got=%h/%b exp=44000000/1000", b_wd[0], b_be[0]); end
    total++; if (b_wd[1] !== 32'h00112233 || b_be[1] !== 4'b0111) begin bad++; $display("FAIL msw_beat1 got=%h/%b exp=00112233/0111", b_wd[1], b_be[1]); end
    total++; if (b_addr[1] !== 32'h104) begin bad++; $display("FAIL msw_addr1 got=%h exp=00000104", b_addr[1]); end
  endtask

  task automatic test_waitrequest();
    int cmds;
    cmds = 0;
    mode = LW;
    addr = 32'h200;
    rw = RW_LOAD;
    waitreq = 1'b1;
    step();
    rw = RW_IDLE;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (read && !waitreq) cmds++;
      total++; if ({read, stall, address, be} !== {1'b1, 1'b1, 32'h200, 4'hF}) begin bad++; $display("FAIL wait_hold%0d got read=%b stall=%b addr=%h be=%b exp 1 1 00000200 1111", i, read, stall, address, be); end
      step();
      #1;
    end
    waitreq = 1'b0;
    #1;
    if (read && !waitreq) cmds++;
    total++; if ({read, address, be} !== {1'b1, 32'h200, 4'hF}) begin bad++; $display("FAIL wait_release got read=%b addr=%h be=%b exp 1 00000200 1111", read, address, be); end
    step();
    rdv = 1'b1;
    readdata = 32'h12345678;
    #1;
    if (read && !waitreq) cmds++;
    total++; if (read !== 1'b0 || stall !== 1'b1) begin bad++; $display("FAIL wait_resp got read=%b stall=%b exp 0 1", read, stall); end
    step();
    rdv = 1'b1;
    readdata = 32'hFFFFFFFF;
    #1;
    total++; if (stall !== 1'b0 || d2r !== 32'h12345678) begin bad++; $display("FAIL wait_done got stall=%b data=%h exp 0 12345678", stall, d2r); end
    step();
    rdv = 1'b0;
    #1;
    if (read && !waitreq) cmds++;
    total++; if (stall !== 1'b0 || read !== 1'b0 || d2r !== 32'h0) begin bad++; $display("FAIL wait_after got stall=%b read=%b data=%h exp 0 0 0", stall, read, d2r); end
    step();
    if (read && !waitreq) cmds++;
    total++; if (cmds !== 1) begin bad++; $display("FAIL wait_cmds got=%0d exp=1", cmds); end
  endtask

  task automatic test_reset_mid();
    mode = LW;
    addr = 32'h300;
    rw = RW_LOAD;
    step();
    rw = RW_IDLE;
    #1;
    total++; if (read !== 1'b1) begin bad++; $display("FAIL mid_req got read=%b exp=1", read); end
    step();
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL mid_resp0 got stall=%b exp=1", stall); end
    reset_n = 1'b0;
    #1;
    total++; if ({read, write, stall} !== 3'b000) begin bad++; $display("FAIL mid_async got read/write/stall=%b exp=000", {read, write, stall}); end
    total++; if (address !== 32'h0 || be !== 4'h0) begin bad++; $display("FAIL mid_async_regs got addr=%h be=%b exp 0 0", address, be); end
    step();
    reset_n = 1'b1;
    rdv = 1'b1;
    readdata = 32'hCAFEF00D;
    #1;
    total++; if (stall !== 1'b0 || read !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL mid_late_rdv got stall=%b read=%b err=%b exp 0 0 0", stall, read, err); end
    step();
    rdv = 1'b0;
    #1;
    total++; if (stall !== 1'b0 || d2r !== 32'h0 || err !== 1'b0) begin bad++; $display("FAIL mid_after got stall=%b data=%h err=%b exp 0 0 0", stall, d2r, err); end
    run_access(LW, 32'h104, 32'h0, RW_LOAD, 32'h0BADCAFE, 32'h0);
    total++; if (got !== 32'h0BADCAFE || cyc !== 3) begin bad++; $display("FAIL mid_recover got data=%h cyc=%0d exp 0badcafe 3", got, cyc); end
  endtask

  task automatic test_illegal();
    mode = LW;
    addr = 32'h100;
    rw = RW_ILL;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL ill_rw_stall got=%b exp=0", stall); end
    step();
    rw = RW_IDLE;
    #1;
    total++; if (err !== 1'b1 || read !== 1'b0 || write !== 1'b0) begin bad++; $display("FAIL ill_rw_err got err=%b read=%b write=%b exp 1 0 0", err, read, write); end
    step();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL ill_rw_pulse got=%b exp=0", err); end
    mode = LD;
    rw = RW_LOAD;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL ill_ld_stall got=%b exp=0", stall); end
    step();
    rw = RW_IDLE;
    #1;
    total++; if (err !== 1'b1 || read !== 1'b0) begin bad++; $display("FAIL ill_ld_err got err=%b read=%b exp 1 0", err, read); end
    step();
    mode = LW;
    addr = 32'h102;
    rw0 = RW_LOAD;
    #1;
    total++; if (stall0 !== 1'b0) begin bad++; $display("FAIL nomis_stall got=%b exp=0", stall0); end
    step();
    rw0 = RW_IDLE;
    #1;
    total++; if (err0 !== 1'b1 || read0 !== 1'b0) begin bad++; $display("FAIL nomis_err got err=%b read=%b exp 1 0", err0, read0); end
    step();
    total++; if (err0 !== 1'b0 || read0 !== 1'b0) begin bad++; $display("FAIL nomis_after got err=%b read=%b exp 0 0", err0, read0); end
  endtask

  initial begin
    test_reset();
    test_aligned_lw();
    test_byte_loads();
    test_store_half();
    test_misaligned();
    test_waitrequest();
    test_reset_mid();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
